// File: rtl/dm.sv
// Debug-module transport types shared by the DMI responder and its clients.
package dm;

  localparam logic [1:0] DTM_NOP   = 2'h0;
  localparam logic [1:0] DTM_READ  = 2'h1;
  localparam logic [1:0] DTM_WRITE = 2'h2;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_responder.sv
// Bridges single DMI requests onto a simple req/gnt/rvalid register bus, one access at a time,
// with an abort-on-timeout guard covering the request and wait phases.
module dmi_responder #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  dm::dmi_req_t dmi_req_i,
  input  logic         dmi_req_valid_i,
  output logic         dmi_req_ready_o,
  output dm::dmi_resp_t dmi_resp_o,
  output logic         dmi_resp_valid_o,
  input  logic         dmi_resp_ready_i,
  output logic         reg_req_o,
  output logic         reg_we_o,
  output logic [6:0]   reg_addr_o,
  output logic [31:0]  reg_wdata_o,
  input  logic         reg_gnt_i,
  input  logic         reg_rvalid_i,
  input  logic [31:0]  reg_rdata_i,
  input  logic         reg_err_i
);

  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_q, rsp_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_hs;
  logic        timeout;

  assign req_hs  = dmi_req_valid_i && (state_q == StIdle);
  assign timeout = (cnt_q == TimeoutLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_d      = rsp_q;
    unique case (state_q)
      StIdle: begin
        if (dmi_req_valid_i) begin
          unique case (dmi_req_i.op)
            dm::DTM_READ, dm::DTM_WRITE: state_d = StReq;
            dm::DTM_NOP: begin
              state_d    = StResp;
              rsp_data_d = '0;
              rsp_d      = dm::DTM_SUCCESS;
            end
            default: begin
              state_d    = StResp;
              rsp_data_d = '0;
              rsp_d      = dm::DTM_ERR;
            end
          endcase
        end
      end
      StReq: begin
        // A grant arriving on the timeout cycle still wins.
        if (reg_gnt_i) begin
          state_d = StWait;
        end else if (timeout) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_d      = dm::DTM_ERR;
        end
      end
      StWait: begin
        if (reg_rvalid_i) begin
          state_d    = StResp;
          rsp_data_d = we_q ? 32'h0 : reg_rdata_i;
          rsp_d      = reg_err_i ? dm::DTM_ERR : dm::DTM_SUCCESS;
        end else if (timeout) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_d      = dm::DTM_ERR;
        end
      end
      StResp: begin
        if (dmi_resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (req_hs) begin
      cnt_d = '0;
    end else if (state_q == StReq || state_q == StWait) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (req_hs) begin
        addr_q  <= dmi_req_i.addr;
        we_q    <= (dmi_req_i.op == dm::DTM_WRITE);
        wdata_q <= dmi_req_i.data;
      end
      rsp_data_q <= rsp_data_d;
      rsp_q      <= rsp_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    dmi_req_ready_o  = (state_q == StIdle);
    dmi_resp_valid_o = (state_q == StResp);
    reg_req_o        = (state_q == StReq);
    reg_we_o         = we_q;
    reg_addr_o       = addr_q;
    reg_wdata_o      = wdata_q;
    dmi_resp_o.data  = rsp_data_q;
    dmi_resp_o.resp  = rsp_q;
  end

endmodule

// File: tb/tb_dmi_responder.sv
// Randomised and directed checks of dmi_responder against a transaction-timeline model.
module tb_dmi_responder;

  localparam int T = 8;

  logic          clk_i;
  logic          rst_ni;
  dm::dmi_req_t  dmi_req_i;
  logic          dmi_req_valid_i;
  logic          dmi_req_ready_o;
  dm::dmi_resp_t dmi_resp_o;
  logic          dmi_resp_valid_o;
  logic          dmi_resp_ready_i;
  logic          reg_req_o;
  logic          reg_we_o;
  logic [6:0]    reg_addr_o;
  logic [31:0]   reg_wdata_o;
  logic          reg_gnt_i;
  logic          reg_rvalid_i;
  logic [31:0]   reg_rdata_i;
  logic          reg_err_i;

  dmi_responder #(.TimeoutCycles(T)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .dmi_req_i       (dmi_req_i),
    .dmi_req_valid_i (dmi_req_valid_i),
    .dmi_req_ready_o (dmi_req_ready_o),
    .dmi_resp_o      (dmi_resp_o),
    .dmi_resp_valid_o(dmi_resp_valid_o),
    .dmi_resp_ready_i(dmi_resp_ready_i),
    .reg_req_o       (reg_req_o),
    .reg_we_o        (reg_we_o),
    .reg_addr_o      (reg_addr_o),
    .reg_wdata_o     (reg_wdata_o),
    .reg_gnt_i       (reg_gnt_i),
    .reg_rvalid_i    (reg_rvalid_i),
    .reg_rdata_i     (reg_rdata_i),
    .reg_err_i       (reg_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle outputs, written by the stimulus process from the transaction plan.
  logic          chk_en = 1'b0;
  logic          exp_ready, exp_req, exp_rv, exp_we;
  logic [6:0]    exp_addr;
  logic [31:0]   exp_wdata;
  dm::dmi_resp_t exp_resp;

  logic          force_noise = 1'b0;
  logic          acc_mark = 1'b0;
  int            lat_cnt, obs_lat, req_cycles;
  logic          seen;
  logic [33:0]   obs_resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic noise();
    return force_noise ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic garble();
    dmi_req_valid_i = noise();
    dmi_req_i       = '{addr: 7'($urandom), op: 2'($urandom), data: $urandom};
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_en) begin
        chk("req_ready", 64'(dmi_req_ready_o), 64'(exp_ready));
        chk("reg_req", 64'(reg_req_o), 64'(exp_req));
        chk("resp_valid", 64'(dmi_resp_valid_o), 64'(exp_rv));
        if (exp_req) begin
          chk("reg_we", 64'(reg_we_o), 64'(exp_we));
          chk("reg_addr", 64'(reg_addr_o), 64'(exp_addr));
          chk("reg_wdata", 64'(reg_wdata_o), 64'(exp_wdata));
        end
        if (exp_rv) chk("resp", 64'(dmi_resp_o), 64'(exp_resp));
        if (acc_mark) begin
          lat_cnt = 0; seen = 1'b0; req_cycles = 0;
        end else begin
          lat_cnt++;
        end
        if (dmi_resp_valid_o && !seen) begin
          seen = 1'b1; obs_lat = lat_cnt; obs_resp = dmi_resp_o;
        end
        if (reg_req_o) req_cycles++;
      end
    end
  end

  // g: REQ-cycle index carrying gnt (>= T means never); r: WAIT-cycle index carrying rvalid;
  // k: cycles resp_ready is held low; gap: idle cycles before the request.
  task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                         input int g, input int r, input logic [31:0] rdata, input logic err,
                         input int k, input int gap);
    dm::dmi_resp_t er;
    int nreq, nwait, tw;
    logic timed_out, rv;
    exp_ready = 1'b1; exp_req = 1'b0; exp_rv = 1'b0;
    dmi_req_valid_i = 1'b0; dmi_resp_ready_i = 1'b0;
    for (int i = 0; i < gap; i++) begin
      reg_gnt_i = noise(); reg_rvalid_i = noise(); reg_rdata_i = $urandom;
      step();
    end
    dmi_req_valid_i = 1'b1;
    dmi_req_i = '{addr: addr, op: op, data: data};
    reg_gnt_i = noise(); reg_rvalid_i = noise();
    acc_mark = 1'b1;
    step();
    acc_mark = 1'b0;
    exp_ready = 1'b0;
    if (op == dm::DTM_NOP) begin
      er = '{data: 32'h0, resp: dm::DTM_SUCCESS};
    end else if (op == 2'd3) begin
      er = '{data: 32'h0, resp: dm::DTM_ERR};
    end else begin
      exp_req = 1'b1; exp_we = (op == dm::DTM_WRITE); exp_addr = addr; exp_wdata = data;
      nreq = (g < T) ? g + 1 : T;
      for (int i = 0; i < nreq; i++) begin
        garble();
        reg_gnt_i = (i == g); reg_rvalid_i = noise(); reg_rdata_i = $urandom;
        step();
      end
      exp_req = 1'b0;
      if (g >= T) begin
        er = '{data: 32'h0, resp: dm::DTM_ERR};
      end else begin
        tw = T - 2 - g;
        timed_out = (tw >= 0) && (r > tw);
        nwait = timed_out ? tw + 1 : r + 1;
        for (int j = 0; j < nwait; j++) begin
          garble();
          rv = !timed_out && (j == r);
          reg_gnt_i = noise(); reg_rvalid_i = rv;
          reg_rdata_i = rv ? rdata : $urandom;
          reg_err_i = rv ? err : 1'($urandom_range(0, 1));
          step();
        end
        if (timed_out) er = '{data: 32'h0, resp: dm::DTM_ERR};
        else er = '{data: (op == dm::DTM_READ) ? rdata : 32'h0,
                    resp: err ? dm::DTM_ERR : dm::DTM_SUCCESS};
      end
    end
    exp_rv = 1'b1; exp_resp = er;
    for (int m = 0; m <= k; m++) begin
      garble();
      reg_gnt_i = noise(); reg_rvalid_i = noise(); reg_rdata_i = $urandom;
      dmi_resp_ready_i = (m == k);
      step();
    end
    exp_rv = 1'b0; exp_ready = 1'b1;
    dmi_resp_ready_i = 1'b0; dmi_req_valid_i = 1'b0;
  endtask

  initial begin
    int pick;
    logic [1:0] op;
    rst_ni = 1'b1;
    dmi_req_i = '0; dmi_req_valid_i = 1'b0; dmi_resp_ready_i = 1'b0;
    reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0; reg_rdata_i = '0; reg_err_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_ready", 64'(dmi_req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(dmi_resp_valid_o), 64'd0);
    chk("rst_resp", 64'(dmi_resp_o), 64'd0);
    chk("rst_reg_req", 64'(reg_req_o), 64'd0);
    chk("rst_reg_we", 64'(reg_we_o), 64'd0);
    chk("rst_reg_addr", 64'(reg_addr_o), 64'd0);
    chk("rst_reg_wdata", 64'(reg_wdata_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    exp_ready = 1'b1; exp_req = 1'b0; exp_rv = 1'b0;
    chk_en = 1'b1;

    // Minimum-latency read
    run_txn(dm::DTM_READ, 7'h11, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 0, 1);
    chk("read_latency", 64'(obs_lat), 64'd3);
    chk("read_resp", 64'(obs_resp), {30'h0, 32'hDEADBEEF, 2'h0});
    chk("read_req_cycles", 64'(req_cycles), 64'd1);

    // Write with delayed grant and bus error
    run_txn(dm::DTM_WRITE, 7'h10, 32'h1, 4, 1, 32'h12345678, 1'b1, 0, 0);
    chk("write_resp", 64'(obs_resp), 64'h2);
    chk("write_req_cycles", 64'(req_cycles), 64'd5);

    // NOP then illegal op
    run_txn(dm::DTM_NOP, 7'h01, 32'hFFFF_FFFF, 0, 0, 32'h0, 1'b0, 0, 0);
    chk("nop_latency", 64'(obs_lat), 64'd1);
    chk("nop_resp", 64'(obs_resp), 64'h0);
    chk("nop_req_cycles", 64'(req_cycles), 64'd0);
    run_txn(2'd3, 7'h02, 32'hA5A5_A5A5, 0, 0, 32'h0, 1'b0, 0, 0);
    chk("op3_latency", 64'(obs_lat), 64'd1);
    chk("op3_resp", 64'(obs_resp), 64'h2);
    chk("op3_req_cycles", 64'(req_cycles), 64'd0);

    // Timeout with late rvalid/gnt held high afterwards
    force_noise = 1'b1;
    run_txn(dm::DTM_READ, 7'h05, 32'h0, 100, 0, 32'h0, 1'b0, 2, 0);
    chk("timeout_req_cycles", 64'(req_cycles), 64'd8);
    chk("timeout_resp", 64'(obs_resp), 64'h2);
    run_txn(dm::DTM_READ, 7'h06, 32'h0, 2, 3, 32'hCAFE_F00D, 1'b0, 0, 2);
    chk("after_timeout_resp", 64'(obs_resp), {30'h0, 32'hCAFE_F00D, 2'h0});
    force_noise = 1'b0;

    // Back-pressured response
    run_txn(dm::DTM_READ, 7'h20, 32'h0, 1, 2, 32'h0BAD_CAFE, 1'b0, 5, 0);
    chk("bp_resp", 64'(obs_resp), {30'h0, 32'h0BAD_CAFE, 2'h0});

    // Reset pulse while in WAIT
    chk_en = 1'b0;
    dmi_req_valid_i = 1'b1;
    dmi_req_i = '{addr: 7'h33, op: dm::DTM_READ, data: 32'h0};
    step();
    dmi_req_valid_i = 1'b0; reg_gnt_i = 1'b1;
    step();
    reg_gnt_i = 1'b0; reg_rvalid_i = 1'b1; reg_rdata_i = 32'h5555_AAAA;
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_ready", 64'(dmi_req_ready_o), 64'd1);
    chk("midrst_resp_valid", 64'(dmi_resp_valid_o), 64'd0);
    chk("midrst_resp", 64'(dmi_resp_o), 64'd0);
    chk("midrst_reg_req", 64'(reg_req_o), 64'd0);
    chk("midrst_reg_addr", 64'(reg_addr_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    reg_rvalid_i = 1'b0;
    exp_ready = 1'b1; exp_req = 1'b0; exp_rv = 1'b0;
    chk_en = 1'b1;
    run_txn(dm::DTM_READ, 7'h11, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0, 0, 2);
    chk("postrst_latency", 64'(obs_lat), 64'd3);
    chk("postrst_resp", 64'(obs_resp), {30'h0, 32'h1357_9BDF, 2'h0});

    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 9);
      op = (pick < 4) ? dm::DTM_READ : (pick < 8) ? dm::DTM_WRITE :
           (pick == 8) ? dm::DTM_NOP : 2'd3;
      run_txn(op, 7'($urandom), $urandom, int'($urandom_range(0, 9)), int'($urandom_range(0, 8)),
              $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmi_responder.md
DMI_RESPONDER -- requirements
Module: dmi_responder

Interface
REQ-001 Parameter TimeoutCycles, default 255, SHALL be the number of cycles a register access may spend in REQ plus WAIT before being aborted; the legal range is 2..65535.
REQ-002 The DMI types from package dm SHALL be used.
- dmi_req_t = {addr[6:0], op[1:0], data[31:0]}, where op NOP=0, READ=1, WRITE=2.
- dmi_resp_t = {data[31:0], resp[1:0]}, where resp SUCCESS=0, ERR=2.
REQ-003 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 dmi_req_i  input  dmi_req_t  incoming DMI request.
REQ-006 dmi_req_valid_i  input  1  request valid.
REQ-007 dmi_req_ready_o  output  1  request accepted when high together with valid.
REQ-008 dmi_resp_o  output  dmi_resp_t  response.
REQ-009 dmi_resp_valid_o  output  1  response valid.
REQ-010 dmi_resp_ready_i  input  1  response consumed.
REQ-011 reg_req_o  output  1  register-bus request.
REQ-012 reg_we_o  output  1  1=write, 0=read.
REQ-013 reg_addr_o  output  7  register address.
REQ-014 reg_wdata_o  output  32  write data.
REQ-015 reg_gnt_i  input  1  register bus accepted the request.
REQ-016 reg_rvalid_i  input  1  access completed.
REQ-017 reg_rdata_i  input  32  read data, valid with rvalid.
REQ-018 reg_err_i  input  1  access error, valid with rvalid.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT and RESP, with at most one request outstanding.
REQ-020 dmi_req_ready_o SHALL be 1 only in IDLE; a handshake SHALL capture addr, op and data into internal registers.
REQ-021 Accepted READ or WRITE SHALL go IDLE->REQ; accepted NOP SHALL go IDLE->RESP with data=0, resp=SUCCESS; accepted op=3 SHALL go IDLE->RESP with data=0, resp=ERR.
REQ-022 In REQ, reg_req_o SHALL be 1 and reg_we_o, reg_addr_o, reg_wdata_o SHALL hold the captured values; reg_gnt_i=1 SHALL move the FSM to WAIT on the same edge.
REQ-023 In all states other than REQ, reg_req_o SHALL be 0.
REQ-024 In WAIT, reg_rvalid_i=1 SHALL move the FSM to RESP and latch the response.
- READ: data=reg_rdata_i.
- WRITE: data=0.
- resp = reg_err_i ? ERR : SUCCESS.
REQ-025 rvalid asserted in the same cycle as gnt (in REQ) SHALL be ignored; completion is recognised only in WAIT.
REQ-026 A 16-bit timeout counter SHALL clear on request accept and increment on every cycle spent in REQ or WAIT.
REQ-027 In a cycle where the counter equals TimeoutCycles-1 and no gnt (in REQ) or rvalid (in WAIT) is present, the FSM SHALL go to RESP with data=0, resp=ERR.
REQ-028 If rvalid (in WAIT) or gnt (in REQ) coincides with the timeout cycle, the normal transition SHALL win.
REQ-029 reg_rvalid_i and reg_gnt_i outside WAIT/REQ respectively SHALL be ignored, including late responses after a timeout.
REQ-030 In RESP, dmi_resp_valid_o SHALL be 1 and dmi_resp_o SHALL be stable until dmi_resp_ready_i=1; that edge SHALL go to IDLE.
REQ-031 After a response handshake, no new request SHALL be accepted in the same cycle (ready rises the next cycle).
REQ-032 Minimum READ latency SHALL be 3 cycles, counted from the accept edge to dmi_resp_valid_o=1, when gnt arrives in the first REQ cycle and rvalid in the first WAIT cycle.
REQ-033 Minimum NOP latency SHALL be 1 cycle.

Reset
REQ-034 rst_ni=0 SHALL asynchronously force IDLE, clear the counter and captured registers, and set every output to 0 except dmi_req_ready_o, which SHALL be 1.
REQ-035 Reset asserted mid-access SHALL discard the access; no response SHALL be produced for it.

Verification
REQ-036 READ addr=0x11, gnt in cycle 1, rvalid with rdata=0xDEADBEEF and err=0 in cycle 2 -> dmi_resp_o={0xDEADBEEF, 0} valid from cycle 3.
REQ-037 WRITE addr=0x10, data=0x1; gnt delayed 4 cycles; rvalid with err=1 -> reg_we_o=1, reg_wdata_o=0x1 held through REQ; response {0, ERR}.
REQ-038 NOP, then op=3 -> responses {0, SUCCESS} after 1 cycle and {0, ERR} after 1 cycle; reg_req_o never asserted.
REQ-039 TimeoutCycles=8, READ with no gnt -> reg_req_o high for 8 cycles then low; response {0, ERR}; a later rvalid is ignored.
REQ-040 dmi_resp_ready_i held 0 for 5 cycles -> dmi_resp_o stable and dmi_req_ready_o=0 throughout; ready=1 on the cycle after the handshake.
REQ-041 rst_ni pulsed low in WAIT -> all outputs reset immediately; the next READ completes normally.
